// File: rtl/ntt_pipe_sequencer.sv
// ntt_pipe_sequencer
//   Control sequencer for a PIPE_LAT-stage streaming NTT datapath. It tracks
//   beats (32 lanes each, BEATS per 1024-point frame) through a valid/last
//   shadow pipeline. It generates the global stage clock-enable and the
//   per-beat twiddle/permutation index. It also handles flush/drain and
//   checks frame alignment.
//
// Parameters
//   BEATS    beats per frame (tw_idx wraps at BEATS-1)
//   PIPE_LAT registered datapath stages being sequenced
//   CNT_W    performance counter width
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready/in_last  upstream beat handshake, in_last = final beat
//   out_valid/out_ready/out_last downstream beat handshake
//   pipe_en                    clock-enable for every datapath stage register
//   tw_idx                     beat index of the beat entering stage 0
//   flush_req/flush_done       drain request / 1-cycle completion pulse
//   frame_err                  sticky in_last misalignment flag
//   frame_cnt, stall_cnt       saturating perf counters
//
// Build option
//   NTT_SEQ_PERF_CNT_EN  when defined, frame_cnt counts emitted last beats and
//                        stall_cnt counts stalled cycles. When undefined,
//                        both outputs are tied to zero and have no registers.

module ntt_pipe_sequencer #(
  parameter int unsigned BEATS    = 32,
  parameter int unsigned PIPE_LAT = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     pipe_en,
  output logic [$clog2(BEATS)-1:0] tw_idx,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned IDX_W = $clog2(BEATS);
  localparam int unsigned OCC_W = $clog2(PIPE_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PIPE_LAT-1:0] v_sr;
  logic [PIPE_LAT-1:0] l_sr;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W-1:0]    occ_nxt;
  logic [IDX_W-1:0]    beat_cnt;
  logic                accept;
  logic                emit;
  logic                flush_fire;

  assign out_valid = v_sr[PIPE_LAT-1];
  assign out_last  = l_sr[PIPE_LAT-1];
  assign pipe_en   = !(out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign tw_idx    = beat_cnt;

  always_comb begin
    occ_nxt = occ;
    case ({accept, emit})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush_req)   state_nxt = FLUSH;
        else if (accept) state_nxt = STREAM;
      end
      STREAM: begin
        if (flush_req)                   state_nxt = FLUSH;
        else if (occ == '0 && !accept)   state_nxt = IDLE;
      end
      FLUSH: begin
        if (flush_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. flush_fire looks at next-cycle occupancy, so the done pulse
  // appears the cycle right after the final emit. An already-empty pipe
  // still spends exactly one cycle in FLUSH.
  always_comb begin
    in_ready   = pipe_en && (state != FLUSH);
    flush_fire = (state == FLUSH) && (occ_nxt == '0);
  end

  // Shadow valid/last pipeline, occupancy, beat index and alignment check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sr       <= '0;
      l_sr       <= '0;
      occ        <= '0;
      beat_cnt   <= '0;
      frame_err  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      if (pipe_en) begin
        v_sr[0] <= accept;
        l_sr[0] <= accept && in_last;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
          v_sr[i] <= v_sr[i-1];
          l_sr[i] <= l_sr[i-1];
        end
      end
      occ        <= occ_nxt;
      flush_done <= flush_fire;
      if (flush_fire) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + IDX_W'(1);
      end
      // in_last never resynchronises the index; misalignment is only flagged
      if (accept && (in_last != (beat_cnt == LAST_IDX))) begin
        frame_err <= 1'b1;
      end
    end
  end

`ifdef NTT_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] frame_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      stall_q <= '0;
    end else begin
      if (emit && out_last && (frame_q != '1)) frame_q <= frame_q + CNT_W'(1);
      if (!pipe_en && (stall_q != '1))         stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign frame_cnt = frame_q;
  assign stall_cnt = stall_q;
`else
  assign frame_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ntt_pipe_sequencer.sv
// tb_ntt_pipe_sequencer
//   Directed bench for ntt_pipe_sequencer (BEATS=32, PIPE_LAT=10, CNT_W=16).
//   Inputs are driven 1 time unit after the rising edge. A negedge monitor
//   keeps an in-order queue of accepted in_last flags and checks every
//   emitted beat against it.

module tb_ntt_pipe_sequencer;

  localparam int BEATS = 32;
  localparam int PL    = 10;
  localparam int CW    = 16;
`ifdef NTT_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last;
  logic          pipe_en;
  logic [4:0]    tw_idx;
  logic          flush_req, flush_done;
  logic          frame_err;
  logic [CW-1:0] frame_cnt, stall_cnt;

  int n_vec  = 0;
  int n_err  = 0;
  int n_emit = 0;
  int cyc    = 0;
  int last_emit_cyc = -1;
  int exp_idx = 0;
  bit exp_err = 1'b0;
  bit sb[$];

  ntt_pipe_sequencer #(.BEATS(BEATS), .PIPE_LAT(PL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .pipe_en    (pipe_en),
    .tw_idx     (tw_idx),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ordering scoreboard: each emitted beat must match the oldest accepted one
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(in_last);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("emit_unexpected", {31'd0, out_valid}, 32'd0);
        else                chk("out_last", {31'd0, out_last}, {31'd0, sb.pop_front()});
        n_emit++;
        last_emit_cyc = cyc;
      end
    end
  end

  // Offer n beats (in_last on index last_pos), holding out_ready low for
  // loop cycles [stall_at, stall_at+stall_len). lat_chk checks the exact
  // out_valid/out_last timing for an unstalled run starting from empty.
  task automatic send(input int n, input int last_pos, input int stall_at,
                      input int stall_len, input bit lat_chk, input bit drain);
    int sent = 0;
    int k = 0;
    while ((sent < n || (drain && sb.size() != 0)) && k < 300) begin
      in_valid  = (sent < n);
      in_last   = (sent < n) && (sent == last_pos);
      out_ready = !(k >= stall_at && k < stall_at + stall_len);
      #1;
      if (!out_ready) begin
        chk("stall_pipe_en", pipe_en, 0);
        chk("stall_in_ready", in_ready, 0);
      end
      if (lat_chk) begin
        chk("lat_out_valid", out_valid, (k >= PL && k < PL + n));
        chk("lat_out_last", out_last, (k == PL + n - 1));
      end
      if (in_valid && in_ready) begin
        chk("tw_idx", tw_idx, exp_idx);
        if (in_last != (exp_idx == BEATS - 1)) exp_err = 1'b1;
        exp_idx = (exp_idx + 1) % BEATS;
        sent++;
      end
      tick();
      chk("frame_err", frame_err, exp_err);
      k++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("beats_sent", sent, n);
    if (drain) chk("drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int e0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; flush_req = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pipe_en", pipe_en, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tw_idx", tw_idx, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Full frame back to back: out_valid 10 cycles after first accept
    send(32, 31, -1, 0, 1'b1, 1'b1);
    chk("stall_cnt_free", stall_cnt, 0);

    // Second frame with 5-cycle downstream stall
    send(32, 31, 15, 5, 1'b0, 1'b1);
    chk("stall_cnt", stall_cnt, PERF ? 5 : 0);
    chk("frame_cnt_2", frame_cnt, PERF ? 2 : 0);
    chk("emits_2frames", n_emit, 64);

    // Early in_last on beat 20: sticky error, index keeps counting
    send(32, 19, -1, 0, 1'b0, 1'b1);
    chk("frame_err_sticky", frame_err, 1);

    // Flush after 7 beats
    send(7, -1, -1, 0, 1'b0, 1'b0);
    e0 = n_emit;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    chk("flush_in_ready", in_ready, 0);
    k = 0;
    while (!flush_done && k < 40) begin
      chk("flush_hold_in_ready", in_ready, 0);
      tick();
      k++;
    end
    chk("flush_done_seen", flush_done, 1);
    chk("flush_emits", n_emit - e0, 7);
    chk("flush_done_timing", cyc, last_emit_cyc + 1);
    tick();
    chk("flush_done_pulse", flush_done, 0);
    chk("post_flush_in_ready", in_ready, 1);
    exp_idx = 0;

    // Flush from idle with empty pipe: one cycle in FLUSH
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    chk("idle_flush_in_ready", in_ready, 0);
    chk("idle_flush_done_early", flush_done, 0);
    tick();
    chk("idle_flush_done", flush_done, 1);
    chk("idle_flush_back", in_ready, 1);
    tick();
    chk("idle_flush_done_pulse", flush_done, 0);
    send(1, -1, -1, 0, 1'b0, 1'b1);

    // Reset with 6 beats in flight, head held at the output
    send(6, -1, -1, 0, 1'b0, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk("pre_rst_out_valid", out_valid, 1);
    out_ready = 1'b0;
    tick();
    chk("pre_rst_held", out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_pipe_en", pipe_en, 1);
    chk("rst_mid_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_idx = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("rst_empty_out_valid", out_valid, 0);
      tick();
    end
    chk("rst_clr_frame_err", frame_err, 0);
    chk("rst_clr_frame_cnt", frame_cnt, 0);
    chk("rst_clr_stall_cnt", stall_cnt, 0);
    chk("rst_clr_tw_idx", tw_idx, 0);
    chk("rst_idle_in_ready", in_ready, 1);

    // Two more aligned frames after reset
    send(32, 31, -1, 0, 1'b0, 1'b1);
    send(32, 31, -1, 0, 1'b0, 1'b1);
    chk("frame_cnt_after_rst", frame_cnt, PERF ? 2 : 0);
    chk("frame_err_clean", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
